// File: rtl/hms_clock_core.sv
// Hour:minute:second timekeeping core with a debounced three-button front end
// and a CLOCK/SETUP mode controller; all state advances on enables from clk.
module hms_clock_core #(
  parameter int CLK_HZ       = 50000000,
  parameter int DEBOUNCE_CYC = 500000,
  parameter int HOUR_MODE_24 = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_sw_mode,
  input  logic       i_sw_pos,
  input  logic       i_sw_inc,
  output logic [5:0] o_sec,
  output logic [5:0] o_min,
  output logic [4:0] o_hour,
  output logic       o_pm,
  output logic       o_mode,
  output logic [1:0] o_position,
  output logic       o_blink,
  output logic       o_sec_tick
);
  localparam int PS_W = $clog2(CLK_HZ);
  localparam int DB_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [PS_W-1:0] PS_MAX = PS_W'(CLK_HZ - 1);
  localparam logic [PS_W-1:0] BL_MAX = PS_W'(CLK_HZ / 2 - 1);
  localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYC - 1);

  typedef enum logic {ST_CLOCK = 1'b0, ST_SETUP = 1'b1} mode_e;
  typedef enum logic [1:0] {POS_SEC = 2'd0, POS_MIN = 2'd1, POS_HOUR = 2'd2} pos_e;

  // Switch vectors are ordered {inc, pos, mode}; all are active-low levels.
  logic [2:0] sw_raw;
  logic [2:0] sync1_q, sync1_d, sync2_q, sync2_d;
  logic [2:0] samp_q, samp_d, lvl_q, lvl_d, press_q, press_d;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic            db_stb;

  mode_e           mode_q, mode_d;
  pos_e            pos_q, pos_d;
  logic [5:0]      sec_q, sec_d, min_q, min_d;
  logic [4:0]      hour_q, hour_d, h_mod;
  logic [PS_W-1:0] ps_q, ps_d, bl_cnt_q, bl_cnt_d;
  logic            tick_q, tick_d, blink_q, blink_d;
  logic            mode_p, pos_p, inc_p;

  assign sw_raw = {i_sw_inc, i_sw_pos, i_sw_mode};

  always_comb begin
    sync1_d  = sw_raw;
    sync2_d  = sync1_q;
    samp_d   = samp_q;
    lvl_d    = lvl_q;
    press_d  = '0;
    db_stb   = (db_cnt_q == DB_MAX);
    db_cnt_d = db_stb ? '0 : db_cnt_q + 1'b1;
    // The level flips only when this sample matches the previous one.
    if (db_stb) begin
      samp_d = sync2_q;
      for (int i = 0; i < 3; i++) begin
        if ((sync2_q[i] == samp_q[i]) && (sync2_q[i] != lvl_q[i])) begin
          lvl_d[i]   = sync2_q[i];
          press_d[i] = ~sync2_q[i];
        end
      end
    end
  end

  always_comb begin
    mode_d   = mode_q;
    pos_d    = pos_q;
    sec_d    = sec_q;
    min_d    = min_q;
    hour_d   = hour_q;
    ps_d     = ps_q;
    tick_d   = 1'b0;
    bl_cnt_d = bl_cnt_q;
    blink_d  = blink_q;
    mode_p   = press_q[0];
    pos_p    = press_q[1] & ~press_q[0];
    inc_p    = press_q[2] & ~press_q[1] & ~press_q[0];

    if (mode_p) begin
      if (mode_q == ST_CLOCK) begin
        mode_d = ST_SETUP;
        pos_d  = POS_SEC;
      end else begin
        mode_d = ST_CLOCK;
      end
    end

    if (mode_q == ST_CLOCK) begin
      bl_cnt_d = '0;
      blink_d  = 1'b0;
      if (ps_q == PS_MAX) begin
        ps_d   = '0;
        tick_d = 1'b1;
        if (sec_q == 6'd59) begin
          sec_d = '0;
          if (min_q == 6'd59) begin
            min_d  = '0;
            hour_d = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
          end else begin
            min_d = min_q + 6'd1;
          end
        end else begin
          sec_d = sec_q + 6'd1;
        end
      end else begin
        // Leaving for SETUP restarts the second from zero on return.
        ps_d = mode_p ? '0 : ps_q + 1'b1;
      end
    end else begin
      ps_d = '0;
      if (bl_cnt_q == BL_MAX) begin
        bl_cnt_d = '0;
        blink_d  = ~blink_q;
      end else begin
        bl_cnt_d = bl_cnt_q + 1'b1;
      end
      if (pos_p) begin
        case (pos_q)
          POS_SEC: pos_d = POS_MIN;
          POS_MIN: pos_d = POS_HOUR;
          default: pos_d = POS_SEC;
        endcase
      end else if (inc_p) begin
        case (pos_q)
          POS_SEC: sec_d  = (sec_q == 6'd59) ? 6'd0 : sec_q + 6'd1;
          POS_MIN: min_d  = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
          default: hour_d = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= '1;
      sync2_q  <= '1;
      samp_q   <= '1;
      lvl_q    <= '1;
      press_q  <= '0;
      db_cnt_q <= '0;
      mode_q   <= ST_CLOCK;
      pos_q    <= POS_SEC;
      sec_q    <= '0;
      min_q    <= '0;
      hour_q   <= '0;
      ps_q     <= '0;
      tick_q   <= 1'b0;
      bl_cnt_q <= '0;
      blink_q  <= 1'b0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      samp_q   <= samp_d;
      lvl_q    <= lvl_d;
      press_q  <= press_d;
      db_cnt_q <= db_cnt_d;
      mode_q   <= mode_d;
      pos_q    <= pos_d;
      sec_q    <= sec_d;
      min_q    <= min_d;
      hour_q   <= hour_d;
      ps_q     <= ps_d;
      tick_q   <= tick_d;
      bl_cnt_q <= bl_cnt_d;
      blink_q  <= blink_d;
    end
  end

  always_comb begin
    h_mod = (hour_q >= 5'd12) ? hour_q - 5'd12 : hour_q;
    if (HOUR_MODE_24 != 0) begin
      o_hour = hour_q;
      o_pm   = 1'b0;
    end else begin
      o_hour = (h_mod == 5'd0) ? 5'd12 : h_mod;
      o_pm   = (hour_q >= 5'd12);
    end
  end

  assign o_sec      = sec_q;
  assign o_min      = min_q;
  assign o_mode     = mode_q;
  assign o_position = pos_q;
  assign o_blink    = blink_q;
  assign o_sec_tick = tick_q;
endmodule
